// File: rtl/clock_pkg.sv
// Shared types, limits and digit helpers for the alarm clock core.
package clock_pkg;

    typedef enum logic {CLOCK, ALARM_SET} mode_t;
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

    localparam logic [5:0] MAX_HOUR = 6'd23;
    localparam logic [5:0] MAX_MIN  = 6'd59;

    function automatic logic [7:0] bcd_split(input logic [5:0] v);
        logic [3:0] tens, ones;
        tens = 4'(v / 6'd10);
        ones = 4'(v % 6'd10);
        return {tens, ones};
    endfunction

    function automatic logic [5:0] to12h(input logic [5:0] h);
        if (h == 6'd0) return 6'd12;
        if (h > 6'd12) return h - 6'd12;
        return h;
    endfunction

    // Up/down step of one field with wrap and no carry into neighbours.
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                             input logic up);
        if (up) return (v == top) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, with synchronous clear.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST) && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   cnt <= '0;
        else if (clr || cnt == LAST)  cnt <= '0;
        else                          cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/clock_alarm_core.sv
// 24-hour clock with editable alarm, snooze, ring timeout and 12/24h display.
module clock_alarm_core
    import clock_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       alarm_en,
    input  logic       mode12,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnD,
    output logic [3:0] h2,
    output logic [3:0] h1,
    output logic [3:0] m2,
    output logic [3:0] m1,
    output logic [3:0] s2,
    output logic [3:0] s1,
    output logic       set_alarm,
    output logic       field_hour,
    output logic       pm,
    output logic       ringing
);
    localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
    localparam logic [6:0] SNZ       = 7'(SNOOZE_MIN);

    logic         tick;
    logic [5:0]   hour, minute, second, alarm_h, alarm_m, snz_h, snz_m;
    logic [5:0]   adv_h, adv_m, adv_s;
    logic [5:0]   disp_h, disp_m, disp_s, shown_h;
    logic [4:0]   btn_prev;
    logic         press_c, press_u, press_l, press_r, press_d;
    logic         edit, alarm_hit, snooze_hit;
    logic [6:0]   snz_sum;
    logic [7:0]   ring_cnt;
    mode_t        mode;
    alarm_state_t state;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .tick  (tick)
    );

    // Previous values reset high so a button held through reset is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) btn_prev <= '1;
        else        btn_prev <= {btnC, btnU, btnL, btnR, btnD};
    end

    assign press_c = btnC & ~btn_prev[4];
    assign press_u = btnU & ~btn_prev[3];
    assign press_l = btnL & ~btn_prev[2];
    assign press_r = btnR & ~btn_prev[1];
    assign press_d = btnD & ~btn_prev[0];

    always_comb begin
        adv_h = hour;
        adv_m = minute;
        adv_s = second;
        if (tick) begin
            if (second != MAX_MIN) adv_s = second + 6'd1;
            else begin
                adv_s = '0;
                if (minute != MAX_MIN) adv_m = minute + 6'd1;
                else begin
                    adv_m = '0;
                    adv_h = (hour == MAX_HOUR) ? 6'd0 : hour + 6'd1;
                end
            end
        end
    end

    // U/D presses while ringing are snooze requests, never edits.
    assign edit       = (state != RINGING) && (press_u ^ press_d);
    assign alarm_hit  = tick && adv_h == alarm_h && adv_m == alarm_m && adv_s == 6'd0;
    assign snooze_hit = tick && adv_h == snz_h && adv_m == snz_m && adv_s == 6'd0;
    assign snz_sum    = {1'b0, minute} + SNZ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {hour, minute, second} <= '0;
            alarm_h    <= 6'd6;
            alarm_m    <= 6'd0;
            mode       <= CLOCK;
            field_hour <= 1'b0;
        end else begin
            if (clr) {hour, minute, second} <= '0;
            else begin
                hour   <= adv_h;
                minute <= adv_m;
                second <= adv_s;
                if (edit && mode == CLOCK) begin
                    if (field_hour) hour   <= wrap_step(adv_h, MAX_HOUR, press_u);
                    else            minute <= wrap_step(adv_m, MAX_MIN, press_u);
                end
            end
            if (edit && mode == ALARM_SET) begin
                if (field_hour) alarm_h <= wrap_step(alarm_h, MAX_HOUR, press_u);
                else            alarm_m <= wrap_step(alarm_m, MAX_MIN, press_u);
            end
            if (press_l && !press_r)      field_hour <= 1'b1;
            else if (press_r && !press_l) field_hour <= 1'b0;
            if (press_c && (mode == ALARM_SET || state != RINGING))
                mode <= (mode == CLOCK) ? ALARM_SET : CLOCK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_h    <= '0;
            snz_m    <= '0;
        end else if (!alarm_en) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (alarm_hit) begin
                    state    <= RINGING;
                    ring_cnt <= '0;
                end
                RINGING: begin
                    if (press_c) state <= IDLE;
                    else if (press_u || press_d) begin
                        state <= SNOOZED;
                        if (snz_sum >= 7'd60) begin
                            snz_m <= 6'(snz_sum - 7'd60);
                            snz_h <= (hour == MAX_HOUR) ? 6'd0 : hour + 6'd1;
                        end else begin
                            snz_m <= snz_sum[5:0];
                            snz_h <= hour;
                        end
                    end else if (tick) begin
                        if (ring_cnt == RING_LAST) state <= IDLE;
                        else                       ring_cnt <= ring_cnt + 8'd1;
                    end
                end
                SNOOZED: if (snooze_hit) begin
                    state    <= RINGING;
                    ring_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        if (mode == ALARM_SET) begin
            disp_h = alarm_h;
            disp_m = alarm_m;
            disp_s = 6'd0;
        end else begin
            disp_h = hour;
            disp_m = minute;
            disp_s = second;
        end
    end

    assign shown_h   = mode12 ? to12h(disp_h) : disp_h;
    assign {h2, h1}  = bcd_split(shown_h);
    assign {m2, m1}  = bcd_split(disp_m);
    assign {s2, s1}  = bcd_split(disp_s);
    assign set_alarm = (mode == ALARM_SET);
    assign pm        = (disp_h >= 6'd12);
    assign ringing   = (state == RINGING);
endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core with a seconds-of-day reference model.
module tb_clock_alarm_core;
    localparam int TD = 4;
    localparam int RS = 3;
    localparam int SM = 5;
    localparam logic [4:0] B_C = 5'b10000, B_U = 5'b01000, B_L = 5'b00100,
                           B_R = 5'b00010, B_D = 5'b00001;

    logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, alarm_en = 1'b0, mode12 = 1'b0;
    logic [4:0] btn = '0;
    logic [3:0] h2, h1, m2, m1, s2, s1;
    logic set_alarm, field_hour, pm, ringing;

    int checks = 0;
    int errors = 0;

    // reference model state: time in seconds of day, alarm/snooze in minutes of day
    int m_cnt, m_t, m_alarm, m_snz, m_st, m_ringc;
    bit m_mode, m_fld;
    bit [4:0] m_prev;

    clock_alarm_core #(.TICK_DIV(TD), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .alarm_en(alarm_en), .mode12(mode12),
        .btnC(btn[4]), .btnU(btn[3]), .btnL(btn[2]), .btnR(btn[1]), .btnD(btn[0]),
        .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
        .set_alarm(set_alarm), .field_hour(field_hour), .pm(pm), .ringing(ringing)
    );

    always #5 clk = ~clk;

    function automatic int edit_t(int t, bit hf, bit up);
        int h, m, s;
        h = t / 3600; m = (t / 60) % 60; s = t % 60;
        if (hf) h = (h + (up ? 1 : 23)) % 24;
        else    m = (m + (up ? 1 : 59)) % 60;
        return h * 3600 + m * 60 + s;
    endfunction

    function automatic int edit_a(int a, bit hf, bit up);
        int h, m;
        h = a / 60; m = a % 60;
        if (hf) h = (h + (up ? 1 : 23)) % 24;
        else    m = (m + (up ? 1 : 59)) % 60;
        return h * 60 + m;
    endfunction

    task automatic model_step();
        bit pc, pu, pl, pr, pd, tk, ed, old_mode, old_fld;
        int tadv, old_st, old_t;
        if (!rst_n) begin
            m_cnt = 0; m_t = 0; m_alarm = 6 * 60; m_snz = 0; m_st = 0; m_ringc = 0;
            m_mode = 0; m_fld = 0; m_prev = 5'h1f;
            return;
        end
        pc = btn[4] & ~m_prev[4]; pu = btn[3] & ~m_prev[3]; pl = btn[2] & ~m_prev[2];
        pr = btn[1] & ~m_prev[1]; pd = btn[0] & ~m_prev[0];
        tk = !clr && (m_cnt == TD - 1);
        m_cnt = (clr || m_cnt == TD - 1) ? 0 : m_cnt + 1;
        tadv = tk ? (m_t + 1) % 86400 : m_t;
        old_st = m_st; old_t = m_t; old_mode = m_mode; old_fld = m_fld;
        if (!alarm_en) m_st = 0;
        else if (old_st == 0) begin
            if (tk && tadv == m_alarm * 60) begin m_st = 1; m_ringc = 0; end
        end else if (old_st == 1) begin
            if (pc) m_st = 0;
            else if (pu || pd) begin m_snz = (old_t / 60 + SM) % 1440; m_st = 2; end
            else if (tk) begin
                m_ringc++;
                if (m_ringc == RS) m_st = 0;
            end
        end else begin
            if (tk && tadv == m_snz * 60) begin m_st = 1; m_ringc = 0; end
        end
        ed = (old_st != 1) && (pu != pd);
        m_t = clr ? 0 : tadv;
        if (!clr && ed && !old_mode) m_t = edit_t(m_t, old_fld, pu);
        if (ed && old_mode) m_alarm = edit_a(m_alarm, old_fld, pu);
        if (pl && !pr) m_fld = 1;
        else if (pr && !pl) m_fld = 0;
        if (pc && (old_mode || old_st != 1)) m_mode = !m_mode;
        m_prev = btn;
    endtask

    function automatic logic [27:0] model_vec();
        int hh, mm, ss, dh;
        if (m_mode) begin hh = m_alarm / 60; mm = m_alarm % 60; ss = 0; end
        else begin hh = m_t / 3600; mm = (m_t / 60) % 60; ss = m_t % 60; end
        dh = hh;
        if (mode12) begin
            if (hh == 0) dh = 12;
            else if (hh > 12) dh = hh - 12;
        end
        return {4'(dh / 10), 4'(dh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                m_mode, m_fld, (hh >= 12), (m_st == 1)};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // per-cycle comparison of every output, plus the internal tick
    initial forever begin
        logic [27:0] dv, mv;
        logic etk;
        @(posedge clk);
        #2;
        dv = {h2, h1, m2, m1, s2, s1, set_alarm, field_hour, pm, ringing};
        mv = model_vec();
        etk = rst_n && !clr && (m_cnt == TD - 1);
        checks++;
        if (dv !== mv) begin
            errors++;
            $display("FAIL cycle_cmp @%0t dut=%h model=%h", $time, dv, mv);
        end
        checks++;
        if (dut.tick !== etk) begin
            errors++;
            $display("FAIL tick_cmp @%0t dut=%b model=%b", $time, dut.tick, etk);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_disp(input string nm, input int hh, input int mm, input int ss);
        logic [23:0] e;
        e = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
        chk(nm, {8'h0, h2, h1, m2, m1, s2, s1}, {8'h0, e});
    endtask

    task automatic press(input logic [4:0] mask);
        btn = mask;
        @(negedge clk);
        btn = '0;
        @(negedge clk);
    endtask

    task automatic press_n(input logic [4:0] mask, input int n);
        for (int i = 0; i < n; i++) press(mask);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_until(input string nm, input int tgt, input bit align, input int lim);
        int n;
        n = 0;
        checks++;
        while (!(m_t == tgt && (!align || m_cnt == TD - 1))) begin
            if (n >= lim) begin
                errors++;
                $display("FAIL %s timeout after %0d cycles, model time=%0d expected=%0d",
                         nm, n, m_t, tgt);
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {4'h0, h2, h1, m2, m1, s2, s1, set_alarm, field_hour, pm, ringing}, 32'h0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk_disp("ten_ticks", 0, 0, 10);

        // hour wrap down, minute wrap down, then run across midnight
        pulse_clr();
        press(B_L); press(B_D); press(B_R); press(B_D); press(B_D);
        chk_disp("wrap_down_edits", 23, 58, 2);
        repeat (500) @(negedge clk);
        chk_disp("midnight_roll", 0, 0, 7);

        // alarm editing
        press(B_C);
        chk("set_alarm_on", {31'h0, set_alarm}, 32'h1);
        chk_disp("alarm_default", 6, 0, 0);
        press(B_L); press(B_D);
        chk_disp("alarm_hour_dec", 5, 0, 0);
        press_n(B_U, 2); press(B_R); press_n(B_U, 30);
        chk_disp("alarm_0730", 7, 30, 0);
        press(B_C);
        chk("set_alarm_off", {31'h0, set_alarm}, 32'h1 ^ 32'h1);

        // edit on the same cycle as a tick carrying 10:59:59
        pulse_clr();
        press(B_L); press_n(B_U, 10); press(B_R); press(B_D);
        wait_until("reach_105959", 10 * 3600 + 59 * 60 + 59, 1'b1, 400);
        btn = B_U;
        @(negedge clk);
        btn = '0;
        chk_disp("tick_plus_edit", 11, 1, 0);
        @(negedge clk);

        // 12-hour display
        mode12 = 1'b1;
        pulse_clr();
        chk("h12_midnight", {24'h0, h2, h1}, 32'h12);
        chk("pm_midnight", {31'h0, pm}, 32'h0);
        press(B_L); press_n(B_U, 13);
        chk("h12_13", {24'h0, h2, h1}, 32'h01);
        chk("pm_13", {31'h0, pm}, 32'h1);
        mode12 = 1'b0;
        @(negedge clk);
        chk("h24_13", {24'h0, h2, h1}, 32'h13);

        // alarm, snooze, ring timeout
        alarm_en = 1'b1;
        pulse_clr();
        press(B_L); press_n(B_U, 7); press(B_R); press_n(B_D, 31);
        wait_until("reach_072959", 7 * 3600 + 29 * 60 + 59, 1'b1, 1000);
        @(negedge clk);
        chk("ring_0730", {31'h0, ringing}, 32'h1);
        chk_disp("time_0730", 7, 30, 0);
        press(B_D);
        chk("snoozed", {31'h0, ringing}, 32'h0);
        chk_disp("snooze_no_edit", 7, 30, 0);
        wait_until("reach_0735", 7 * 3600 + 35 * 60, 1'b0, 1400);
        chk("ring_0735", {31'h0, ringing}, 32'h1);
        repeat (4 * RS - 1) @(negedge clk);
        chk("ring_before_timeout", {31'h0, ringing}, 32'h1);
        @(negedge clk);
        chk("ring_timeout", {31'h0, ringing}, 32'h0);

        // dismiss leaves mode alone
        press(B_C); press_n(B_U, 6);
        chk_disp("alarm_0736", 7, 36, 0);
        press(B_C);
        wait_until("reach_0736", 7 * 3600 + 36 * 60, 1'b0, 400);
        chk("ring_0736", {31'h0, ringing}, 32'h1);
        press(B_C);
        chk("dismiss_ring", {31'h0, ringing}, 32'h0);
        chk("dismiss_mode", {31'h0, set_alarm}, 32'h0);

        // reset while ringing
        press(B_C); press(B_U); press(B_C);
        wait_until("reach_0737", 7 * 3600 + 37 * 60, 1'b0, 400);
        chk("ring_0737", {31'h0, ringing}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_ring", {4'h0, h2, h1, m2, m1, s2, s1, set_alarm, field_hour, pm, ringing}, 32'h0);

        // button held across reset release
        btn = B_U;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        btn = '0;
        @(negedge clk);
        chk("held_btn_no_edit", {16'h0, h2, h1, m2, m1}, 32'h0);

        // simultaneous inputs
        press(B_U | B_D);
        chk("u_and_d_no_change", {24'h0, m2, m1}, 32'h00);
        press(B_U);
        chk("single_u", {24'h0, m2, m1}, 32'h01);
        press(B_L);
        chk("field_hour_sel", {31'h0, field_hour}, 32'h1);
        press(B_L | B_R);
        chk("l_and_r_no_change", {31'h0, field_hour}, 32'h1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
